// File: rtl/rs_line_pkg.sv
// Shared types and helpers for the rs_line dispatcher/collector family.
package rs_line_pkg;

    localparam int RS_STAT_W = 32;

    // Index width for n lanes; never narrower than one bit.
    function automatic int LANE_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_line_rr_ctr.sv
// Nested line/lane counter: NUM_LINES lines per lane, lanes visited round-robin.
module rs_line_rr_ctr
    import rs_line_pkg::*;
#(
    parameter int NUM_LINES   = 1,
    parameter int NUM_OUTPUTS = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                adv,
    output logic [LANE_IDX_W(NUM_OUTPUTS)-1:0]  lane_sel,
    output logic                                last_line
);

    localparam int CW = LANE_IDX_W(NUM_LINES);
    localparam int LW = LANE_IDX_W(NUM_OUTPUTS);

    logic [CW-1:0] line_cnt;

    assign last_line = (line_cnt == CW'(NUM_LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
            lane_sel <= '0;
        end else if (adv) begin
            if (last_line) begin
                line_cnt <= '0;
                lane_sel <= (lane_sel == LW'(NUM_OUTPUTS - 1)) ? '0 : lane_sel + 1'b1;
            end else begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_line_1_to_n.sv
// Deals a line stream out to NUM_OUTPUTS encoder lanes in blocks of NUM_LINES.
// Optional RS_LINE_1_TO_N_STATS_EN adds block/stall counters and current-lane output.
module rs_line_1_to_n
    import rs_line_pkg::*;
#(
    parameter int NUM_OUTPUTS = 32,
    parameter int DATA_W      = -1,
    parameter int NUM_LINES   = -1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src_1_to_n_line_val,
    input  logic [DATA_W-1:0]       src_1_to_n_line_data,
    output logic                    rs_1_to_n_src_line_rdy,
    output logic [NUM_OUTPUTS-1:0]  rs_1_to_n_dst_line_vals,
    output logic [DATA_W-1:0]       rs_1_to_n_dst_line_data,
    input  logic [NUM_OUTPUTS-1:0]  dst_1_to_n_line_rdys
`ifdef RS_LINE_1_TO_N_STATS_EN
    ,
    output logic [RS_STAT_W-1:0]                rs_1_to_n_blocks_sent,
    output logic [RS_STAT_W-1:0]                rs_1_to_n_stall_cycles,
    output logic [LANE_IDX_W(NUM_OUTPUTS)-1:0]  rs_1_to_n_cur_lane
`endif
);

    localparam int LW = LANE_IDX_W(NUM_OUTPUTS);

    generate
        if (NUM_OUTPUTS < 1) begin : g_bad_outputs
            $error("rs_line_1_to_n: NUM_OUTPUTS must be >= 1");
        end
        if (DATA_W < 1) begin : g_bad_data_w
            $error("rs_line_1_to_n: DATA_W must be overridden with a value >= 1");
        end
        if (NUM_LINES < 1) begin : g_bad_lines
            $error("rs_line_1_to_n: NUM_LINES must be overridden with a value >= 1");
        end
    endgenerate

    logic              hold_val;
    logic [DATA_W-1:0] hold_data;
    logic [LW-1:0]     hold_idx;
    logic [LW-1:0]     lane_sel;
    logic              last_line;
    logic              sel_rdy;
    logic              acc;
    logic              drain;

    // Only the held lane's ready matters; the others are deliberately ignored.
    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (hold_idx == LW'(i)) sel_rdy = dst_1_to_n_line_rdys[i];
        end
    end

    assign rs_1_to_n_src_line_rdy = ~hold_val | sel_rdy;
    assign acc   = src_1_to_n_line_val & rs_1_to_n_src_line_rdy;
    assign drain = hold_val & sel_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_val  <= 1'b0;
            hold_data <= '0;
            hold_idx  <= '0;
        end else if (acc) begin
            hold_val  <= 1'b1;
            hold_data <= src_1_to_n_line_data;
            hold_idx  <= lane_sel;
        end else if (drain) begin
            hold_val  <= 1'b0;
        end
    end

    rs_line_rr_ctr #(
        .NUM_LINES   (NUM_LINES),
        .NUM_OUTPUTS (NUM_OUTPUTS)
    ) u_rr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (acc),
        .lane_sel  (lane_sel),
        .last_line (last_line)
    );

    generate
        for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_lane_val
            assign rs_1_to_n_dst_line_vals[g] = hold_val & (hold_idx == LW'(g));
        end
    endgenerate

    assign rs_1_to_n_dst_line_data = hold_data;

`ifdef RS_LINE_1_TO_N_STATS_EN
    logic [RS_STAT_W-1:0] blocks_q;
    logic [RS_STAT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_q <= '0;
            stall_q  <= '0;
        end else begin
            if (acc && last_line)   blocks_q <= blocks_q + 1'b1;
            if (hold_val && !sel_rdy) stall_q <= stall_q + 1'b1;
        end
    end

    assign rs_1_to_n_blocks_sent  = blocks_q;
    assign rs_1_to_n_stall_cycles = stall_q;
    assign rs_1_to_n_cur_lane     = lane_sel;
`endif

endmodule

// File: tb/tb_rs_line_1_to_n.sv
// Directed bench for rs_line_1_to_n: a 4x3 instance and a 32x1 instance, scoreboard-checked.
module tb_rs_line_1_to_n;

    localparam int NO [2] = '{4, 32};
    localparam int NL [2] = '{3, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        val_a, val_b;
    logic [7:0]  din;
    logic [3:0]  rdys_a;
    logic [31:0] rdys_b;
    logic        rdy_a, rdy_b;
    logic [3:0]  vals_a;
    logic [31:0] vals_b;
    logic [7:0]  data_a, data_b;
`ifdef RS_LINE_1_TO_N_STATS_EN
    logic [31:0] blocks_a, stall_a, blocks_b, stall_b;
    logic [1:0]  cur_a;
    logic [4:0]  cur_b;
`endif

    typedef struct {
        int lane;
        int data;
    } ent_t;

    ent_t sb [2][$];
    int   k [2];
    int   n_vec = 0;
    int   n_err = 0;
    int   stall_seen = 0;

    always #5 clk = ~clk;

    rs_line_1_to_n #(.NUM_OUTPUTS(4), .DATA_W(8), .NUM_LINES(3)) u_a (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .src_1_to_n_line_val     (val_a),
        .src_1_to_n_line_data    (din),
        .rs_1_to_n_src_line_rdy  (rdy_a),
        .rs_1_to_n_dst_line_vals (vals_a),
        .rs_1_to_n_dst_line_data (data_a),
        .dst_1_to_n_line_rdys    (rdys_a)
`ifdef RS_LINE_1_TO_N_STATS_EN
        ,
        .rs_1_to_n_blocks_sent   (blocks_a),
        .rs_1_to_n_stall_cycles  (stall_a),
        .rs_1_to_n_cur_lane      (cur_a)
`endif
    );

    rs_line_1_to_n #(.NUM_OUTPUTS(32), .DATA_W(8), .NUM_LINES(1)) u_b (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .src_1_to_n_line_val     (val_b),
        .src_1_to_n_line_data    (din),
        .rs_1_to_n_src_line_rdy  (rdy_b),
        .rs_1_to_n_dst_line_vals (vals_b),
        .rs_1_to_n_dst_line_data (data_b),
        .dst_1_to_n_line_rdys    (rdys_b)
`ifdef RS_LINE_1_TO_N_STATS_EN
        ,
        .rs_1_to_n_blocks_sent   (blocks_b),
        .rs_1_to_n_stall_cycles  (stall_b),
        .rs_1_to_n_cur_lane      (cur_b)
`endif
    );

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, got, exp);
        end
    endtask

    // Scoreboard head is the line the DUT should be holding; lane comes from the accept index.
    task automatic model(input int d, input logic [31:0] vals, input logic [31:0] rdys,
                         input logic rdy, input logic [7:0] data, input logic v);
        logic exp_rdy;
        ent_t e;
        exp_rdy = (sb[d].size() == 0) || rdys[sb[d][0].lane];
        chk("src_rdy", d, {31'b0, rdy}, {31'b0, exp_rdy});
        if (sb[d].size() != 0) begin
            chk("dst_vals", d, vals, 32'(1) << sb[d][0].lane);
            chk("dst_data", d, {24'b0, data}, sb[d][0].data);
        end else begin
            chk("dst_vals_idle", d, vals, 32'b0);
        end
        if (rst_n) begin
            if (sb[d].size() != 0 && rdys[sb[d][0].lane]) sb[d].delete(0);
            if (v && exp_rdy) begin
                e.lane = (k[d] / NL[d]) % NO[d];
                e.data = int'(din);
                sb[d].push_back(e);
                k[d]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model(0, {28'b0, vals_a}, {28'b0, rdys_a}, rdy_a, data_a, val_a);
        model(1, vals_b, rdys_b, rdy_b, data_b, val_b);
        if (!rdy_a) stall_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb[0].delete();
        sb[1].delete();
        k[0] = 0;
        k[1] = 0;
    endtask

    initial begin
        rst_n  = 1'b0;
        val_a  = 1'b1;
        val_b  = 1'b1;
        din    = 8'hAA;
        rdys_a = 4'hF;
        rdys_b = '1;
        clear_model();

        // reset with valid high: nothing emitted, ready high, data cleared
        @(posedge clk);
        #1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_data", 0, {24'b0, data_a}, 32'h0);
        chk("rst_data", 1, {24'b0, data_b}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        val_a = 1'b0;
        val_b = 1'b0;
        repeat (3) tick();

        // 24 back-to-back lines through the 4x3 instance
        for (int i = 0; i < 24; i++) begin
            din   = 8'(i);
            val_a = 1'b1;
            tick();
        end
        val_a = 1'b0;
        repeat (2) tick();
`ifdef RS_LINE_1_TO_N_STATS_EN
        chk("blocks_sent", 0, blocks_a, 32'd8);
        chk("stall_cycles", 0, stall_a, 32'd0);
        chk("cur_lane", 0, {30'b0, cur_a}, 32'd0);
`endif

        // hold the 4th line of a rotation on lane 1 for 5 cycles
        for (int i = 0; i < 4; i++) begin
            din   = 8'(24 + i);
            val_a = 1'b1;
            tick();
        end
        din = 8'd28;
        stall_seen = 0;
        for (int c = 0; c < 5; c++) begin
            rdys_a = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom)};
            tick();
        end
        rdys_a = 4'hF;
        tick();
        val_a = 1'b0;
        repeat (2) tick();
        chk("stall_len", 0, 32'(stall_seen), 32'd5);
`ifdef RS_LINE_1_TO_N_STATS_EN
        chk("blocks_sent", 0, blocks_a, 32'd9);
        chk("stall_cycles", 0, stall_a, 32'd5);
        chk("cur_lane", 0, {30'b0, cur_a}, 32'd1);
`endif

        // 33 lines through the 32x1 instance: one lane per line, wrapping to 0
        for (int i = 0; i < 33; i++) begin
            din   = 8'(i);
            val_b = 1'b1;
            tick();
        end
        val_b = 1'b0;
        repeat (2) tick();
`ifdef RS_LINE_1_TO_N_STATS_EN
        chk("blocks_sent", 1, blocks_b, 32'd33);
        chk("stall_cycles", 1, stall_b, 32'd0);
        chk("cur_lane", 1, {27'b0, cur_b}, 32'd1);
`endif

        // fresh start, 8 lines so the last two sit in lane 2, then reset mid-block
        rst_n = 1'b0;
        clear_model();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            din   = 8'(100 + i);
            val_a = 1'b1;
            tick();
        end
        val_a = 1'b0;
        rst_n = 1'b0;
        clear_model();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din   = 8'(200 + i);
            val_a = 1'b1;
            tick();
        end
        val_a = 1'b0;
        repeat (2) tick();
`ifdef RS_LINE_1_TO_N_STATS_EN
        chk("blocks_sent", 0, blocks_a, 32'd1);
        chk("stall_cycles", 0, stall_a, 32'd0);
        chk("cur_lane", 0, {30'b0, cur_a}, 32'd1);
`endif
        chk("sb_empty", 0, 32'(sb[0].size()), 32'd0);
        chk("sb_empty", 1, 32'(sb[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
